// File: rtl/sobel_window_gen.sv
// 3x3 neighbourhood generator for the Sobel path: two line buffers plus a register window.
// Optional overflow resynchronisation is enabled by defining SOBEL_WIN_RESYNC_EN.
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int COL_WIDTH  = 8,
  parameter int ROW_WIDTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  fifo_data_in,
  input  logic        fifo_empty_in,
  input  logic        fifo_overflow_in,
  input  logic        ready_in,
  output logic        rd_ack_out,
  output logic [71:0] window_out,
  output logic        window_valid_out,
  output logic        frame_done_out,
  output logic        sync_err_out
);

  localparam int AW = $clog2(IMG_WIDTH);
  localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(IMG_WIDTH - 1);
  localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(IMG_HEIGHT - 1);
  localparam logic [0:0] ST_ACTIVE    = 1'b0;
  localparam logic [0:0] ST_FRAME_END = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [ROW_WIDTH-1:0] row_q, row_d;
  logic [COL_WIDTH-1:0] col_q, col_d;
  logic [71:0]          win_q, win_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [7:0]           lb0_q [0:IMG_WIDTH-1];
  logic [7:0]           lb1_q [0:IMG_WIDTH-1];
  logic [AW-1:0]        addr_s;
  logic [7:0]           lb0_rd_s, lb1_rd_s;
  logic                 ovf_s, pop_s;

`ifdef SOBEL_WIN_RESYNC_EN
  assign ovf_s = fifo_overflow_in;
`else
  logic unused_ovf_s;
  assign unused_ovf_s = fifo_overflow_in;
  assign ovf_s = 1'b0;
`endif

  assign pop_s    = (state_q == ST_ACTIVE) && !fifo_empty_in && ready_in && !reset && !ovf_s;
  assign addr_s   = col_q[AW-1:0];
  assign lb0_rd_s = lb0_q[addr_s];
  assign lb1_rd_s = lb1_q[addr_s];

  // Next-state: window shift, position counters, frame state and status flags.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    win_d   = win_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    if (ovf_s) begin
      row_d   = {ROW_WIDTH{1'b0}};
      col_d   = {COL_WIDTH{1'b0}};
      state_d = ST_ACTIVE;
      err_d   = 1'b1;
    end else if (pop_s) begin
      for (int r = 0; r < 3; r++) begin
        win_d[(3*r)*8 +: 8]   = win_q[(3*r+1)*8 +: 8];
        win_d[(3*r+1)*8 +: 8] = win_q[(3*r+2)*8 +: 8];
      end
      win_d[2*8 +: 8] = lb1_rd_s;
      win_d[5*8 +: 8] = lb0_rd_s;
      win_d[8*8 +: 8] = fifo_data_in;
      // Stale columns from the previous line are hidden by the col >= 2 gate.
      valid_d = (row_q >= ROW_WIDTH'(2)) && (col_q >= COL_WIDTH'(2));
      if (col_q == COL_LAST) begin
        col_d = {COL_WIDTH{1'b0}};
        if (row_q == ROW_LAST) begin
          row_d   = {ROW_WIDTH{1'b0}};
          state_d = ST_FRAME_END;
          done_d  = 1'b1;
        end else begin
          row_d = row_q + ROW_WIDTH'(1);
        end
      end else begin
        col_d = col_q + COL_WIDTH'(1);
      end
    end else if (state_q == ST_FRAME_END) begin
      state_d = ST_ACTIVE;
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ACTIVE;
      row_q   <= {ROW_WIDTH{1'b0}};
      col_q   <= {COL_WIDTH{1'b0}};
      win_q   <= 72'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Line buffers are never reset; every location is rewritten before it reaches a valid window.
  always_ff @(posedge clk) begin
    if (pop_s) begin
      lb1_q[addr_s] <= lb0_rd_s;
      lb0_q[addr_s] <= fifo_data_in;
    end
  end

  assign rd_ack_out       = pop_s;
  assign window_out       = win_q;
  assign window_valid_out = valid_q;
  assign frame_done_out   = done_q;
  assign sync_err_out     = err_q;

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Downstream consumer of the 8-bit pixel FIFO in the Sobel edge-detection path. It pops raster-order pixels whenever the FIFO is non-empty and the Sobel kernel is ready. It keeps two line buffers plus a 3x3 register window, and emits one fully-populated 3x3 neighbourhood per interior pixel to the Sobel kernel stage. It tracks row/column position, flags end of frame, and optionally resynchronises on FIFO overflow.

## Interface
Parameters:
- IMG_WIDTH, 64, pixels per line; 3 ≤ IMG_WIDTH ≤ 2^COL_WIDTH
- IMG_HEIGHT, 64, lines per frame; 3 ≤ IMG_HEIGHT ≤ 2^ROW_WIDTH
- COL_WIDTH, 8, column counter width
- ROW_WIDTH, 8, row counter width

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- fifo_data_in  in  8  FIFO head pixel, valid combinationally whenever fifo_empty_in=0
- fifo_empty_in  in  1  FIFO empty flag
- fifo_overflow_in  in  1  FIFO overflow pulse
- ready_in  in  1  Sobel stage can accept a window next cycle
- rd_ack_out  out  1  pop strobe to FIFO (combinational)
- window_out  out  72  3x3 window; pixel (r,c) at bits [(3r+c)*8 +: 8]; r=0 oldest line, c=0 oldest column
- window_valid_out  out  1  window_out valid, one-cycle pulse
- frame_done_out  out  1  one-cycle pulse after last pixel of frame
- sync_err_out  out  1  sticky: frame aborted by overflow (SOBEL_WIN_RESYNC_EN only; else tied 0)

## Operation
- States: ACTIVE, FRAME_END. Reset → ACTIVE.
- rd_ack_out = (state==ACTIVE) && !fifo_empty_in && ready_in. A cycle with rd_ack_out=1 is a pop, and fifo_data_in is consumed in that cycle.
- On a pop at position (row, col) with pixel p:
  - Read lb1[col] and lb0[col].
  - Write lb1[col] ← lb0[col] and lb0[col] ← p.
  - Window shifts left one column. The new column c=2 = {lb1[col], lb0[col], p} for rows 0,1,2.
  - col increments. When col == IMG_WIDTH-1, col → 0 and row increments.
- Line buffers are two IMG_WIDTH×8 RAMs with one read and one write per pop at the same address. Read-before-write is required. Contents are not cleared by reset.
- window_valid_out is registered: it is 1 in the cycle after a pop with row ≥ 2 and col ≥ 2, and 0 otherwise. The window is centred on pixel (row-1, col-1). Edge pixels (row 0, last row, col 0, last col) never produce a window.
- Popping the last pixel (row=IMG_HEIGHT-1, col=IMG_WIDTH-1):
  - row and col → 0.
  - Next cycle: state=FRAME_END, frame_done_out=1, final window_valid_out=1.
  - No pop occurs in FRAME_END. Next state is ACTIVE.
- window_out holds its value when there is no pop. Stale columns from the previous line are masked by the col ≥ 2 gate.
- Counters are plain binary with explicit wrap at IMG_WIDTH-1 and IMG_HEIGHT-1. No arithmetic is done on pixel data.

## Timing
- Reset values:
  - rd_ack_out = 0 during reset.
  - window_valid_out = 0, frame_done_out = 0, sync_err_out = 0, window_out = 0.
  - row = 0, col = 0, state = ACTIVE.
- Pop-to-window latency is 1 cycle. Maximum throughput is one pixel per cycle, except one bubble per frame (FRAME_END).
- ready_in=0 stalls pops with no data loss. The window and counters freeze.
- fifo_empty_in=1 behaves the same as ready_in=0.
- Reset asserted mid-frame: the next frame restarts at (0,0) and the partial frame is discarded. Reset has priority over pops.

## Configuration
- SOBEL_WIN_RESYNC_EN defined:
  - fifo_overflow_in=1 forces row, col → 0, state → ACTIVE, and sync_err_out → 1 (sticky until reset).
  - window_valid_out is suppressed that cycle.
  - rd_ack_out is forced to 0 that cycle.
- SOBEL_WIN_RESYNC_EN not defined:
  - fifo_overflow_in is ignored.
  - sync_err_out is constant 0.
  - Counters continue undisturbed.

## Test plan
- IMG_WIDTH=4, IMG_HEIGHT=3, FIFO streams pixels 0..11 with ready_in=1:
  - After pop of 10, window_out bytes (c0..c8) = 0,1,2,4,5,6,8,9,10 and window_valid_out=1.
  - After pop of 11, bytes = 1,2,3,5,6,7,9,10,11, with window_valid_out=1 and frame_done_out=1 in the same cycle.
  - Exactly 2 valid windows per frame.
- Same stream with ready_in toggled every other cycle and random fifo_empty_in gaps → identical windows in identical order, no duplicates, and rd_ack_out never 1 while empty or not ready.
- Two back-to-back frames (pixels 0..11, then 100..111) → second frame first window = 100,101,102,104,105,106,108,109,110, and exactly one bubble cycle between frames.
- Reset asserted after pixel 6, then stream 0..11 → outputs match a clean single frame, with no window from the aborted data.
- With SOBEL_WIN_RESYNC_EN: overflow pulse after pixel 5 → sync_err_out=1 next cycle and stays 1. A subsequent stream 0..11 yields the two windows above. Without the macro, the same stimulus gives sync_err_out=0 and the counter continues from 6.
